// File: rtl/csa_pkg.sv
// Shared constants, stage-count helper and per-stage control record for csa_pipe.
// With CSA_PIPE_OVF_EN defined the record also carries the carry into the MSB.
package csa_pkg;

  localparam int unsigned CSA_DEF_WIDTH = 32;
  localparam int unsigned CSA_DEF_BLOCK = 4;

  // A zero or oversized BLOCK still yields one stage so elaboration reaches the config check.
  function automatic int unsigned num_blk(input int unsigned width, input int unsigned block);
    return ((block == 0) || (width < block)) ? 1 : width / block;
  endfunction

  typedef struct packed {
    logic valid;
    logic carry;
    logic sub;
`ifdef CSA_PIPE_OVF_EN
    logic msb_cin;
`endif
  } stage_ctl_t;

endpackage

// File: rtl/csa_pipe_if.sv
// Operand-issue and result-writeback handshake bundle for csa_pipe.
// CSA_PIPE_OVF_EN adds the out_ovf signal.
interface csa_pipe_if
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef CSA_PIPE_OVF_EN
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
`ifdef CSA_PIPE_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout
`ifdef CSA_PIPE_OVF_EN
    , output out_ovf
`endif
  );

endinterface

// File: rtl/csa_block.sv
// Combinational BLOCK-bit carry-select slice: two ripple chains, one per carry-in,
// with the real carry-in choosing between them.
module csa_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout
);

  logic [BLOCK-1:0] s0;
  logic [BLOCK-1:0] s1;
  logic             co0;
  logic             co1;

  always_comb begin
    logic c0;
    logic c1;
    // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
    s0 = '0;
    s1 = '0;
    c0 = 1'b0;
    c1 = 1'b1;
    // NOTE: blocking assignments here model the ripple: each bit sees the carry just computed.
    for (int i = 0; i < BLOCK; i++) begin
      s0[i] = a[i] ^ b[i] ^ c0;
      c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
      s1[i] = a[i] ^ b[i] ^ c1;
      c1    = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
    end
    co0 = c0;
    co1 = c1;
  end

  assign s    = cin ? s1  : s0;
  assign cout = cin ? co1 : co0;

endmodule

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder/subtractor resolving one BLOCK-bit slice per stage.
// Define CSA_PIPE_OVF_EN to add the signed-overflow output out_ovf.
module csa_pipe
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_DEF_WIDTH,
  parameter int unsigned BLOCK = CSA_DEF_BLOCK
) (
  input logic       clk,
  input logic       rst,
  csa_pipe_if.slave io
);

  localparam int unsigned NUM_BLK = num_blk(WIDTH, BLOCK);

  if ((BLOCK == 0) || ((WIDTH % ((BLOCK == 0) ? 1 : BLOCK)) != 0)) begin : g_bad_cfg
    $error("csa_pipe: WIDTH (%0d) must be a multiple of a non-zero BLOCK (%0d)", WIDTH, BLOCK);
  end

  // word rotates right by BLOCK each stage: the low slice is the next A operand slice,
  // finished sums enter at the top, so after NUM_BLK stages it holds the sum in order.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t stage_q [NUM_BLK];
  stage_t stage_d [NUM_BLK];
  logic   adv;

  assign adv         = !io.out_valid || io.out_ready;
  assign io.in_ready = adv;

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_stage
    logic [WIDTH-1:0] word_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             sub_in;
    logic             valid_in;
    logic [BLOCK-1:0] a_sl;
    logic [BLOCK-1:0] b_sl;
    logic [BLOCK-1:0] s_sl;
    logic             cout_sl;
    stage_t           d;

    if (k == 0) begin : g_head
      assign word_in  = io.in_a;
      assign b_in     = io.in_b;
      assign cin_in   = io.in_sub | io.in_cin;
      assign sub_in   = io.in_sub;
      assign valid_in = io.in_valid;
    end else begin : g_body
      assign word_in  = stage_q[k-1].word;
      assign b_in     = stage_q[k-1].b;
      assign cin_in   = stage_q[k-1].ctl.carry;
      assign sub_in   = stage_q[k-1].ctl.sub;
      assign valid_in = stage_q[k-1].ctl.valid;
    end

    // B travels raw and is inverted slice by slice under the carried sub flag.
    assign a_sl = word_in[BLOCK-1:0];
    assign b_sl = b_in[BLOCK-1:0] ^ {BLOCK{sub_in}};

    csa_block #(.BLOCK(BLOCK)) u_blk (
      .a    (a_sl),
      .b    (b_sl),
      .cin  (cin_in),
      .s    (s_sl),
      .cout (cout_sl)
    );

    always_comb begin
      d           = '0;
      d.ctl.valid = valid_in;
      d.ctl.carry = cout_sl;
      d.ctl.sub   = sub_in;
`ifdef CSA_PIPE_OVF_EN
      d.ctl.msb_cin = a_sl[BLOCK-1] ^ b_sl[BLOCK-1] ^ s_sl[BLOCK-1];
`endif
      d.word = (word_in >> BLOCK) | (WIDTH'(s_sl) << (WIDTH - BLOCK));
      d.b    = b_in >> BLOCK;
    end

    assign stage_d[k] = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every stage, data included, is cleared so a flushed op can never resurface.
      for (int k = 0; k < NUM_BLK; k++) begin
        stage_q[k] <= '0;
      end
    end else if (adv) begin
      stage_q <= stage_d;
    end
  end

  assign io.out_valid = stage_q[NUM_BLK-1].ctl.valid;
  assign io.out_sum   = stage_q[NUM_BLK-1].word;
  assign io.out_cout  = stage_q[NUM_BLK-1].ctl.carry;
`ifdef CSA_PIPE_OVF_EN
  assign io.out_ovf   = stage_q[NUM_BLK-1].ctl.msb_cin ^ stage_q[NUM_BLK-1].ctl.carry;
`endif

endmodule

// File: tb/tb_csa_pipe.sv
// Self-checking bench for csa_pipe: directed vectors, random stream, backpressure and
// reset flushes, scored against a plain-arithmetic reference model.
module tb_csa_pipe;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned BLOCK   = 4;
  localparam int unsigned NUM_BLK = WIDTH / BLOCK;
  localparam int          TIMEOUT = 200;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  csa_pipe_if #(.WIDTH(WIDTH)) bus ();

  csa_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  int   n_checks    = 0;
  int   n_pass      = 0;
  int   n_out       = 0;
  int   ready_drops = 0;
  res_t exp_q [$];
  res_t mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    res_t            r;
    longint unsigned ua;
    longint unsigned ub;
    longint          sa;
    longint          sb;
    longint          sr;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r.sum  = a - b;
      r.cout = (ua >= ub);
      sr     = sa - sb;
    end else begin
      r.sum  = a + b + WIDTH'(cin);
      r.cout = ((ua + ub + 64'(cin)) >> WIDTH) != 0;
      sr     = sa + sb + 64'(cin);
    end
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on every output transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && !bus.in_ready) ready_drops++;
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        check("result_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("stream_sum", 64'(bus.out_sum), 64'(mon_e.sum));
          check("stream_cout", 64'(bus.out_cout), 64'(mon_e.cout));
`ifdef CSA_PIPE_OVF_EN
          check("stream_ovf", 64'(bus.out_ovf), 64'(mon_e.ovf));
`endif
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
    end
  end

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    logic acc;
    int   guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < TIMEOUT);
    if (!acc) check("accept_timeout", 64'(acc), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < TIMEOUT) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 64'(bus.out_valid), 64'(1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_out_sum"}, 64'(bus.out_sum), 64'(0));
    check({tag, "_out_cout"}, 64'(bus.out_cout), 64'(0));
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
`ifdef CSA_PIPE_OVF_EN
    check({tag, "_out_ovf"}, 64'(bus.out_ovf), 64'(0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t             vecs [7];
    int               cyc;
    int               base;
    int               seen;
    logic [WIDTH-1:0] held;

    vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // Directed vectors: latency, sum, carry and overflow against fixed answers.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_out(cyc);
      check($sformatf("vec%0d_latency", i), 64'(cyc + 1), 64'(NUM_BLK));
      check($sformatf("vec%0d_sum", i), 64'(bus.out_sum), 64'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 64'(bus.out_cout), 64'(vecs[i].cout));
`ifdef CSA_PIPE_OVF_EN
      check($sformatf("vec%0d_ovf", i), 64'(bus.out_ovf), 64'(vecs[i].ovf));
`endif
    end
    @(posedge clk);
    #1;

    // Back-to-back stream: no stalls, and all 20 drain in the minimum time.
    base = n_out;
    seen = ready_drops;
    for (int i = 0; i < 20; i++)
      drive($urandom(), $urandom(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    repeat (NUM_BLK) @(posedge clk);
    #1;
    check("stream_ready_drops", 64'(ready_drops - seen), 64'(0));
    check("stream_out_count", 64'(n_out - base), 64'(20));
    check("stream_drained", 64'(exp_q.size()), 64'(0));

    // Backpressure: stall the output for 5 cycles while inputs keep arriving.
    fork
      begin
        for (int i = 0; i < 10; i++)
          drive($urandom(), $urandom(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
      begin
        wait_out(cyc);
        bus.out_ready = 1'b0;
        held          = bus.out_sum;
        repeat (5) begin
          @(negedge clk);
          check("stall_sum", 64'(bus.out_sum), 64'(held));
          check("stall_valid", 64'(bus.out_valid), 64'(1));
          check("stall_in_ready", 64'(bus.in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    cyc = 0;
    while (exp_q.size() != 0 && cyc < TIMEOUT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    @(posedge clk);
    #1;
    check("bp_drained", 64'(exp_q.size()), 64'(0));
    check("bp_idle_after_drain", 64'(bus.out_valid), 64'(0));

    // Reset with three ops in flight: none may ever emerge.
    for (int i = 0; i < 3; i++)
      drive($urandom(), $urandom(), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("flight_rst");
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("flushed_results", 64'(seen), 64'(0));

    // Reset during an output stall clears everything regardless of out_ready.
    drive(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0);
    wait_out(cyc);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("stall_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("stall_rst_in_ready", 64'(bus.in_ready), 64'(1));
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csa_pipe.md
Name: csa_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 4-bit carry-select adder.
- Operand width is split into BLOCK-bit slices. Each slice precomputes sum/carry for carry-in 0 and 1; the registered carry from the previous slice selects between them.
- One slice is resolved per pipeline stage, with valid/ready handshakes at both ends.
- Sits between operand-issue logic and the result writeback in the arithmetic datapath.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of BLOCK.
- BLOCK, 4, bits per carry-select slice.
- NUM_BLK, WIDTH/BLOCK, number of slices and pipeline stages. Derived; not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operands present.
- in_ready, output, 1, pipeline can accept this cycle.
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B.
- in_cin, input, 1, carry-in. Ignored when in_sub=1.
- in_sub, input, 1, 1 = A - B (B inverted, carry-in forced to 1).
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer accepts result.
- out_sum, output, WIDTH, result.
- out_cout, output, 1, carry-out of MSB slice. For subtract, 1 means no borrow.

Behaviour:
- Reset: one clk edge with rst=1 clears every stage valid bit and all data registers. After reset: out_valid=0, out_sum=0, out_cout=0, in_ready=1. Any in-flight operations are discarded.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All stages shift together when adv=1 and all hold when adv=0. Bubbles are not collapsed.
- Accept: in_valid && in_ready.
  - Stage 0 captures A, effective B (B ^ {WIDTH{in_sub}}), effective cin (in_sub ? 1 : in_cin).
  - Stage 0 resolves slice 0 from those values.
- Stage k (1..NUM_BLK-1):
  - Takes the registered carry of stage k-1.
  - Selects the precomputed cin=0 or cin=1 result for slice k.
  - Registers the slice sum, carry, and the remaining unresolved operand bits.
- Resolved sum bits and not-yet-resolved operand bits travel as a single WIDTH-wide word per stage. Only the upper slices' operands are needed; unused register bits may be optimised away.
- Latency: with out_ready held 1, a result accepted on cycle t has out_valid=1 on cycle t+NUM_BLK. Throughput is 1 op/cycle.
- Output hold: while out_valid && !out_ready, out_sum, out_cout and all internal stages are stable.
- Wrap-around: arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on out_cout.
- Simultaneous accept and output drain in the same cycle is legal and loses no data.
- rst asserted mid-stall also clears everything; out_ready is ignored during reset.
- Elaboration error (generate-time check) if WIDTH % BLOCK != 0 or BLOCK < 1.
- NUM_BLK = 1: single stage, latency 1.

Optional Feature:
- Macro: CSA_PIPE_OVF_EN.
- When defined:
  - Extra output port out_ovf, 1 bit.
  - Signed overflow = carry into MSB XOR carry out of MSB, registered alongside out_cout.
  - Reset value 0; held stable during stall.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package csa_pkg holds:
  - default WIDTH/BLOCK constants;
  - a function computing NUM_BLK;
  - a typedef for the per-stage register record: valid, word, carry, sub flag (plus the MSB carry-in when CSA_PIPE_OVF_EN).
- Sub-module csa_block: combinational BLOCK-bit slice.
  - Inputs a, b, cin.
  - Outputs s, cout.
  - Internally two ripple chains (cin=0, cin=1) selected by cin.
  - Instantiated NUM_BLK times in a generate loop.

Test Plan:
- WIDTH=32, BLOCK=4, out_ready=1. A=0x0000_0001, B=0x0000_0002, cin=0 -> after 8 cycles out_sum=0x0000_0003, out_cout=0.
- Full carry ripple: A=0xFFFF_FFFF, B=0x0000_0000, cin=1 -> out_sum=0x0000_0000, out_cout=1. With CSA_PIPE_OVF_EN: out_ovf=0.
- Subtract: A=5, B=7, in_sub=1 -> out_sum=0xFFFF_FFFE, out_cout=0. A=7, B=5, in_sub=1 -> out_sum=2, out_cout=1.
- Back-to-back stream of 20 random ops with out_ready=1 -> in_ready never drops, and results appear in order, one per cycle, matching the reference model.
- Backpressure: drop out_ready for 5 cycles while a result is valid -> out_sum is stable and in_ready=0. Release -> no op is lost or duplicated.
- Reset mid-flight: 3 ops in pipe, assert rst for 1 cycle -> next cycle out_valid=0, out_sum=0, in_ready=1, and none of the 3 results ever appear.
